cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one physical-memory cacheline port between the I-cache miss path (port a side) and the D-cache miss/writeback path (port b side) of the 5-stage pipeline.
- Sits between the two caches and main memory.
- Serves one cacheline transaction at a time through a registered FSM.
- Routes the memory response back to the owning cache only.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, memory address width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-cache line read request.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  I-cache transaction complete.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  D-cache transaction complete.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data.
- mem_resp  in  1  memory transaction complete.
- grant  out  2  current owner: 00 none, 01 I-cache, 10 D-cache.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE. The state is a register.
- Reset (rst=0, asynchronous): state=IDLE, grant=00, last_grant=I. All strobes and resps are 0 while reset is asserted.
- Reset mid-transaction: the transaction is abandoned and no resp is issued. Memory is expected to be reset by the same signal.
- IDLE:
  - Samples the requests each cycle.
  - Only I pending -> SERVE_I. Only D pending -> SERVE_D (pending means d_read|d_write).
  - Both pending -> winner chosen by the priority policy (see Optional Feature).
  - None pending -> stay in IDLE.
- SERVE_I:
  - mem_read=1, mem_write=0, mem_address=i_address, grant=01.
  - i_resp=mem_resp (combinational pass-through); i_rdata=mem_rdata.
  - On mem_resp=1 -> DONE, and last_grant<=I.
- SERVE_D:
  - mem_read=d_read & ~d_write, mem_write=d_write, mem_address=d_address, mem_wdata=d_wdata, grant=10.
  - d_resp=mem_resp; d_rdata=mem_rdata.
  - On mem_resp=1 -> DONE, and last_grant<=D.
- DONE:
  - Exactly one cycle. All strobes and resps are 0; requests are ignored.
  - Purpose: a requester whose read/write is still high in the cycle after resp is not re-granted.
  - Always -> IDLE.
- Latency: a request seen in IDLE at cycle N gives a memory strobe at N+1. Resp is same-cycle with mem_resp. Minimum spacing between two grants is 2 idle cycles (DONE then IDLE).
- Address and data are not latched. Requesters hold address, wdata and request stable until their resp; the arbiter forwards them combinationally.
- A requester that drops its request mid-SERVE does not abort the transaction. The FSM waits for mem_resp.
- The non-granted resp is always 0. i_rdata and d_rdata may both carry mem_rdata; only the resp qualifies the data.
- d_read and d_write both 1 is illegal: d_write wins. A simulation-only assertion flags it.
- mem_read and mem_write are never both 1. Strobes are 0 in IDLE and DONE.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin tie-break. When both requests are pending in IDLE, grant the requester that is not last_grant. Neither cache can be starved.
- Undefined: fixed priority, D-cache always wins a tie. last_grant is still maintained but unused.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_read=1 -> grant=00 and mem_read=0 throughout. After release, mem_read=1 with mem_address=i_address one cycle later.
- Lone I read: i_address=0x00000060; mem_resp pulses after 5 cycles with mem_rdata=0xA5..A5 -> i_resp=1 that same cycle with i_rdata=0xA5..A5, d_resp=0. Then 1 cycle in DONE with mem_read=0.
- D writeback: d_write=1, d_address=0x000001E0, d_wdata=0x1234..., then mem_resp -> mem_write=1 with that address and data, mem_read=0, d_resp=1, grant=10.
- Tie, fixed build: i_read and d_read asserted together and held -> D is served first, then I. With CACHE_ARB_RR_EN and last_grant=D, I is served first.
- Stuck request: a requester holds its request for 1 cycle after resp -> DONE blocks it and there is no second mem strobe in that cycle. If it is still held in IDLE, it is treated as a new request.
- Mid-transfer reset: rst=0 during SERVE_D -> mem_write drops to 0 asynchronously and no d_resp is issued. After release, state is IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter_if
//  Description : Bundle of the I-cache, D-cache and memory-side cacheline
//                signals around cache_mem_arbiter. The arbiter connects
//                through the master modport, because it drives the memory
//                bus. The environment (caches and memory) connects through
//                the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  // current owner
  logic [1:0]        grant;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata, grant
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata, grant
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one memory cacheline port between the I-cache miss
//                path and the D-cache miss/writeback path. The arbiter serves
//                one line transaction at a time. Address and data pass
//                through combinationally, and each response goes back only
//                to the cache that owns the transaction.
//                Optional build macro CACHE_ARB_RR_EN: when it is defined,
//                a tie is broken round-robin. Otherwise the D-cache always
//                wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active-low
  cache_mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t last_grant_q, last_grant_d;

  logic i_pending;
  logic d_pending;
  logic tie_to_d;

  assign i_pending = bus.i_read;
  assign d_pending = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_RR_EN
  // A tie goes to whoever was not served last, so neither cache can starve.
  assign tie_to_d = (last_grant_q == GNT_I);
`else
  // Fixed priority: the D-cache wins every tie.
  assign tie_to_d = 1'b1;
`endif

  // Line data goes to both caches; only the owner's resp qualifies it.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  // State and last-owner registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state selection and decode of the memory bus for the current owner.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = {ADDR_W{1'b0}};
    bus.mem_wdata   = {LINE_W{1'b0}};
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    bus.grant       = 2'b00;

    case (state_q)
      IDLE: begin
        if (i_pending && d_pending) begin
          state_d = tie_to_d ? SERVE_D : SERVE_I;
        end else if (i_pending) begin
          state_d = SERVE_I;
        end else if (d_pending) begin
          state_d = SERVE_D;
        end
      end

      SERVE_I: begin
        bus.grant       = 2'b01;
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.i_address;
        bus.i_resp      = bus.mem_resp;
        if (bus.mem_resp) begin
          state_d      = DONE;
          last_grant_d = GNT_I;
        end
      end

      SERVE_D: begin
        bus.grant       = 2'b10;
        // A read and a write together is illegal; the write wins.
        bus.mem_read    = bus.d_read & ~bus.d_write;
        bus.mem_write   = bus.d_write;
        bus.mem_address = bus.d_address;
        bus.mem_wdata   = bus.d_wdata;
        bus.d_resp      = bus.mem_resp;
        if (bus.mem_resp) begin
          state_d      = DONE;
          last_grant_d = GNT_D;
        end
      end

      // One quiet cycle, so a request still held just after its resp is
      // not granted a second time.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  // The D-cache must never raise a read and a writeback together.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bus.d_read && bus.d_write));

  // The memory strobes must never both be active.
  a_mem_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bus.mem_read && bus.mem_write));

  // In DONE, last_grant must name the cache that was just served.
  a_last_grant_tracks: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE) |-> ((last_grant_q == GNT_D) == $past(state_q == SERVE_D)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter. A directed section
//                covers reset, a lone I-cache read, a D-cache writeback, a
//                stuck request, a tie and a mid-transfer reset. It is followed
//                by randomized cache and memory traffic, which is compared
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_mem_arbiter;

`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  cache_mem_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

  cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference-model state. owner: 0 none, 1 I-cache, 2 D-cache.
  int          owner, last_srv, mem_cnt;
  bit          quiet;
  bit          ia, da, dw, i_stuck, d_stuck, req_i, req_d, mresp;
  logic [31:0] ia_addr, da_addr;
  logic [255:0] dwd, rdat;
  logic [1:0]  e_grant;
  bit          e_mrd, e_mwr;

  logic [255:0] pat_a5;
  logic [255:0] pat_12;
  int           first_g, second_g;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_12 = {16{16'h1234}};
    rst = 1'b0;
    bus.i_read = 1'b1;  bus.i_address = 32'h0000_0060;
    bus.d_read = 1'b0;  bus.d_write = 1'b0;
    bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;

    // ---------------- reset held for 3 cycles with i_read high ----------------
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_grant", bus.grant, 2'b00);
      chk("rst_mem_read", bus.mem_read, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_idle_grant", bus.grant, 2'b00);
    tick; #1;
    chk("post_rst_mem_read", bus.mem_read, 1'b1);
    chk("post_rst_addr", bus.mem_address, 32'h0000_0060);
    chk("post_rst_grant", bus.grant, 2'b01);

    // ---------------- lone I read, memory answers 5 cycles later ----------------
    for (int k = 0; k < 4; k++) tick;
    bus.mem_resp = 1'b1; bus.mem_rdata = pat_a5;
    #1;
    chk("i_read_resp", bus.i_resp, 1'b1);
    chk("i_read_data", bus.i_rdata, pat_a5);
    chk("i_read_dresp", bus.d_resp, 1'b0);
    tick;
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    #1;
    chk("i_done_mem_read", bus.mem_read, 1'b0);
    chk("i_done_grant", bus.grant, 2'b00);
    chk("i_done_iresp", bus.i_resp, 1'b0);
    tick;

    // ---------------- D writeback, held one cycle past resp ----------------
    bus.d_write = 1'b1; bus.d_address = 32'h0000_01E0; bus.d_wdata = pat_12;
    tick; #1;
    chk("d_wr_mem_write", bus.mem_write, 1'b1);
    chk("d_wr_mem_read", bus.mem_read, 1'b0);
    chk("d_wr_addr", bus.mem_address, 32'h0000_01E0);
    chk("d_wr_wdata", bus.mem_wdata, pat_12);
    chk("d_wr_grant", bus.grant, 2'b10);
    tick;
    bus.mem_resp = 1'b1;
    #1;
    chk("d_wr_dresp", bus.d_resp, 1'b1);
    chk("d_wr_iresp", bus.i_resp, 1'b0);
    tick;
    bus.mem_resp = 1'b0;
    #1;
    // The request is still held here, but DONE must keep the bus idle.
    chk("stuck_done_mem_write", bus.mem_write, 1'b0);
    chk("stuck_done_mem_read", bus.mem_read, 1'b0);
    chk("stuck_done_grant", bus.grant, 2'b00);
    tick; #1;
    chk("stuck_idle_grant", bus.grant, 2'b00);
    tick; #1;
    // A request still held in IDLE counts as a new request.
    chk("stuck_regrant", bus.grant, 2'b10);
    chk("stuck_regrant_write", bus.mem_write, 1'b1);
    bus.mem_resp = 1'b1;
    #1 chk("stuck_second_dresp", bus.d_resp, 1'b1);
    tick;
    bus.mem_resp = 1'b0; bus.d_write = 1'b0;
    tick;

    // ---------------- tie: both requests together, last served = D ----------------
    first_g  = RR ? 1 : 2;
    second_g = RR ? 2 : 1;
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0100;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_0200;
    tick; #1;
    chk("tie_first_grant", bus.grant, first_g[1:0]);
    bus.mem_resp = 1'b1;
    #1;
    chk("tie_first_iresp", bus.i_resp, first_g == 1);
    chk("tie_first_dresp", bus.d_resp, first_g == 2);
    tick;
    bus.mem_resp = 1'b0;
    if (first_g == 1) bus.i_read = 1'b0; else bus.d_read = 1'b0;
    tick; tick; #1;
    chk("tie_second_grant", bus.grant, second_g[1:0]);
    chk("tie_second_addr", bus.mem_address, (second_g == 1) ? 32'h0000_0100 : 32'h0000_0200);
    bus.mem_resp = 1'b1;
    tick;
    bus.mem_resp = 1'b0; bus.i_read = 1'b0; bus.d_read = 1'b0;
    tick;

    // ---------------- mid-transfer reset during a writeback ----------------
    bus.d_write = 1'b1; bus.d_address = 32'h0000_0400; bus.d_wdata = pat_12;
    tick; #1;
    chk("mid_rst_pre_write", bus.mem_write, 1'b1);
    #1;
    rst = 1'b0; bus.mem_resp = 1'b1;
    #1;
    chk("mid_rst_write_drop", bus.mem_write, 1'b0);
    chk("mid_rst_no_dresp", bus.d_resp, 1'b0);
    chk("mid_rst_grant", bus.grant, 2'b00);
    @(negedge clk);
    rst = 1'b1; bus.mem_resp = 1'b0; bus.d_write = 1'b0;
    #1 chk("mid_rst_after_grant", bus.grant, 2'b00);
    tick; #1;
    chk("mid_rst_idle_grant", bus.grant, 2'b00);
    chk("mid_rst_idle_write", bus.mem_write, 1'b0);

    // ---------------- randomized traffic against the reference model ----------------
    rst = 1'b0;
    tick;
    rst = 1'b1;
    owner = 0; last_srv = 1; quiet = 1'b0; mem_cnt = 0;
    ia = 1'b0; da = 1'b0; dw = 1'b0; i_stuck = 1'b0; d_stuck = 1'b0;
    ia_addr = '0; da_addr = '0; dwd = '0;
    for (int c = 0; c < 800; c++) begin
      // Cache agents raise new requests and hold them until their resp.
      if (!ia && !i_stuck && $urandom_range(0, 99) < 35) begin
        ia = 1'b1; ia_addr = $urandom & 32'hFFFF_FFE0;
      end
      if (!da && !d_stuck && $urandom_range(0, 99) < 35) begin
        da = 1'b1; da_addr = $urandom & 32'hFFFF_FFE0;
        dw = $urandom_range(0, 1) == 1;
        dwd = {8{$urandom}};
      end
      req_i = ia || i_stuck;
      req_d = da || d_stuck;
      mresp = (owner != 0) && (mem_cnt == 0);
      rdat  = {8{$urandom}};
      bus.i_read = req_i; bus.i_address = ia_addr;
      bus.d_read = req_d && !dw; bus.d_write = req_d && dw;
      bus.d_address = da_addr; bus.d_wdata = dwd;
      bus.mem_resp = mresp; bus.mem_rdata = rdat;
      #1;
      e_grant = owner[1:0];
      e_mrd   = (owner == 1) || (owner == 2 && !dw);
      e_mwr   = (owner == 2) && dw;
      chk("rnd_grant", bus.grant, e_grant);
      chk("rnd_mem_read", bus.mem_read, e_mrd);
      chk("rnd_mem_write", bus.mem_write, e_mwr);
      chk("rnd_i_resp", bus.i_resp, mresp && owner == 1);
      chk("rnd_d_resp", bus.d_resp, mresp && owner == 2);
      if (owner != 0)
        chk("rnd_addr", bus.mem_address, (owner == 1) ? ia_addr : da_addr);
      if (e_mwr)
        chk("rnd_wdata", bus.mem_wdata, dwd);
      if (mresp && owner == 1) chk("rnd_i_rdata", bus.i_rdata, rdat);
      if (mresp && owner == 2) chk("rnd_d_rdata", bus.d_rdata, rdat);
      @(posedge clk);
      // After a completion the bus stays quiet for one cycle. An idle bus
      // grants a pending cache by the tie policy, and a busy bus waits for
      // the memory.
      i_stuck = 1'b0; d_stuck = 1'b0;
      if (quiet) begin
        quiet = 1'b0;
      end else if (owner == 0) begin
        if (req_i && req_d)
          owner = RR ? ((last_srv == 2) ? 1 : 2) : 2;
        else if (req_i)
          owner = 1;
        else if (req_d)
          owner = 2;
        if (owner != 0) mem_cnt = $urandom_range(0, 4);
      end else if (mresp) begin
        if (owner == 1) begin
          ia = 1'b0; i_stuck = $urandom_range(0, 2) == 0;
        end else begin
          da = 1'b0; d_stuck = $urandom_range(0, 2) == 0;
        end
        last_srv = owner;
        owner = 0;
        quiet = 1'b1;
      end else begin
        mem_cnt--;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
